// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory arbiter and its lane aligner.
// The size codes match the load/store unit's req_size field.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    // Byte-lane write enables; lane k carries byte address offset k.
    function automatic logic [3:0] lane_we(input logic [1:0] size, input logic [1:0] k);
        case (size)
            SZ_BYTE: lane_we = 4'b0001 << k;
            SZ_HALF: lane_we = 4'b0011 << k;
            SZ_WORD: lane_we = 4'b1111;
            default: lane_we = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bus between the two requesters, the arbiter and dmem.
// Port p of each packed request field sits at slice p.
interface dmem_arbiter_if;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_write;
    logic [3:0]  req_size;
    logic [1:0]  req_unsigned;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_rdata;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_write, req_size, req_unsigned, dmem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, dmem_addr, dmem_wdata, dmem_we
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_write, req_size, req_unsigned,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport mem (
        input  dmem_addr, dmem_wdata, dmem_we,
        output dmem_rdata
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational store lane placement and load extraction / sign extension.
// Store and load sides have independent inputs so a caller can place and extract in different cycles.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_k,
    input  logic [31:0] st_data,
    output logic [3:0]  st_we,
    output logic [31:0] st_lanes,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_k,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [7:0]         lane [4];
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic signed [31:0] sx_byte;
    logic signed [31:0] sx_half;

    always_comb begin
        st_we    = lane_we(st_size, st_k);
        st_lanes = '0;
        case (st_size)
            SZ_BYTE: st_lanes = {24'b0, st_data[7:0]} << {st_k, 3'b000};
            SZ_HALF: st_lanes = {16'b0, st_data[15:0]} << {st_k, 3'b000};
            SZ_WORD: st_lanes = st_data;
            default: st_lanes = '0;
        endcase
    end

    // dmem returns byte offset 0 on the most significant lane of the read word.
    always_comb begin
        for (int j = 0; j < 4; j++) lane[j] = ld_raw[8*(3-j) +: 8];
    end

    always_comb begin
        ld_byte = lane[ld_k];
        ld_half = {lane[{ld_k[1], 1'b1}], lane[{ld_k[1], 1'b0}]};
        sx_byte = 32'(signed'(ld_byte));
        sx_half = 32'(signed'(ld_half));
        ld_data = '0;
        case (ld_size)
            SZ_BYTE: ld_data = ld_unsigned ? {24'b0, ld_byte} : sx_byte;
            SZ_HALF: ld_data = ld_unsigned ? {16'b0, ld_half} : sx_half;
            SZ_WORD: ld_data = {lane[3], lane[2], lane[1], lane[0]};
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: accept one request, drive dmem for one cycle, answer the next.
// Misaligned, out-of-range and illegal-size requests take the same path with write enables held off.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int PRIO_MODE = 0,
    parameter int MEM_BYTES = 128
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    state_t      state;
    logic        last_gnt;
    logic        win;
    logic        accept;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [1:0]  sel_size;
    logic        sel_write;
    logic        sel_uns;
    logic        sel_err;
    logic [3:0]  place_we;
    logic [31:0] place_wdata;
    logic [31:0] load_data;

    logic        port_p1;
    logic        write_p1;
    logic        err_p1;
    logic [31:0] addr_p1;
    logic [1:0]  size_p1;
    logic        uns_p1;

    function automatic logic access_err(input logic [31:0] addr, input logic [1:0] size);
        logic [32:0] span;
        logic        misaligned;
        span       = {31'b0, size == SZ_WORD, size != SZ_BYTE};
        misaligned = (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00);
        access_err = (size == 2'd3) || misaligned || ({1'b0, addr} + span >= 33'(MEM_BYTES));
    endfunction

    always_comb begin
        win = 1'b0;
        if (PRIO_MODE == 1) begin
            win = ~bus.req_valid[0];
        end else begin
            case (bus.req_valid)
                2'b01:   win = 1'b0;
                2'b10:   win = 1'b1;
                2'b11:   win = ~last_gnt;
                default: win = 1'b0;
            endcase
        end
    end

    always_comb begin
        sel_addr  = win ? bus.req_addr[63:32]  : bus.req_addr[31:0];
        sel_wdata = win ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
        sel_size  = win ? bus.req_size[3:2]    : bus.req_size[1:0];
        sel_write = bus.req_write[win];
        sel_uns   = bus.req_unsigned[win];
        sel_err   = access_err(sel_addr, sel_size);
    end

    assign accept        = rst_n && (state == ST_IDLE) && bus.req_valid[win];
    assign bus.req_ready = accept ? (win ? 2'b10 : 2'b01) : 2'b00;

    dmem_lane_align u_align (
        .st_size     (sel_size),
        .st_k        (sel_addr[1:0]),
        .st_data     (sel_wdata),
        .st_we       (place_we),
        .st_lanes    (place_wdata),
        .ld_size     (size_p1),
        .ld_k        (addr_p1[1:0]),
        .ld_unsigned (uns_p1),
        .ld_raw      (bus.dmem_rdata),
        .ld_data     (load_data)
    );

    // p1: accepted request fields, consumed by load extraction during ACC
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p1 <= sel_addr;
            size_p1 <= sel_size;
            uns_p1  <= sel_uns;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            last_gnt       <= 1'b1;
            port_p1        <= 1'b0;
            write_p1       <= 1'b0;
            err_p1         <= 1'b0;
            bus.rsp_valid  <= 2'b00;
            bus.rsp_rdata  <= '0;
            bus.rsp_err    <= 1'b0;
            bus.dmem_addr  <= '0;
            bus.dmem_wdata <= '0;
            bus.dmem_we    <= 4'b0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        last_gnt      <= win;
                        port_p1       <= win;
                        write_p1      <= sel_write;
                        err_p1        <= sel_err;
                        bus.dmem_addr <= sel_addr;
                        if (sel_write && !sel_err) begin
                            bus.dmem_we    <= place_we;
                            bus.dmem_wdata <= place_wdata;
                        end else begin
                            bus.dmem_we    <= 4'b0000;
                            bus.dmem_wdata <= '0;
                        end
                        state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    bus.dmem_we    <= 4'b0000;
                    bus.dmem_wdata <= '0;
                    bus.rsp_valid  <= port_p1 ? 2'b10 : 2'b01;
                    bus.rsp_err    <= err_p1;
                    bus.rsp_rdata  <= (err_p1 || write_p1) ? 32'h0 : load_data;
                    state          <= ST_RSP;
                end
                ST_RSP: begin
                    bus.rsp_valid <= 2'b00;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_rdata <= '0;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance with a byte-array dmem model
// and a fixed-priority instance used for the arbitration sequence.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_arbiter_if b0();
    dmem_arbiter_if b1();

    dmem_arbiter #(.PRIO_MODE(0), .MEM_BYTES(128)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    dmem_arbiter #(.PRIO_MODE(1), .MEM_BYTES(128)) u_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    // dmem model: write lane j -> byte base+j; byte base+j read back on rdata[31-8j:24-8j]
    logic [7:0] mem [128];
    always_comb begin
        b0.dmem_rdata = {mem[{b0.dmem_addr[6:2], 2'd0}], mem[{b0.dmem_addr[6:2], 2'd1}],
                         mem[{b0.dmem_addr[6:2], 2'd2}], mem[{b0.dmem_addr[6:2], 2'd3}]};
    end
    always @(posedge clk) begin
        for (int j = 0; j < 4; j++)
            if (b0.dmem_we[j]) mem[{b0.dmem_addr[6:2], 2'(j)}] <= b0.dmem_wdata[8*j +: 8];
    end
    assign b1.dmem_rdata = 32'h0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge with the arbiter idle.
    task automatic access(input int p, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] exp_we, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd, input logic exp_err, input string tag);
        int n;
        b0.req_addr[32*p +: 32]  = addr;
        b0.req_wdata[32*p +: 32] = wd;
        b0.req_write[p]          = wr;
        b0.req_size[2*p +: 2]    = sz;
        b0.req_unsigned[p]       = uns;
        b0.req_valid[p]          = 1'b1;
        #1;
        n = 0;
        while (!b0.req_ready[p] && n < 8) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "/ready"}, {31'b0, b0.req_ready[p]}, 32'd1);
        @(posedge clk); #1;
        b0.req_valid[p] = 1'b0;
        check({tag, "/acc_we"}, {28'b0, b0.dmem_we}, {28'b0, exp_we});
        check({tag, "/acc_addr"}, b0.dmem_addr, addr);
        if (exp_we != 4'b0000) check({tag, "/acc_wdata"}, b0.dmem_wdata, exp_wd);
        @(posedge clk); #1;
        check({tag, "/rsp_valid"}, {30'b0, b0.rsp_valid}, (p == 1) ? 32'd2 : 32'd1);
        check({tag, "/rsp_rdata"}, b0.rsp_rdata, exp_rd);
        check({tag, "/rsp_err"}, {31'b0, b0.rsp_err}, {31'b0, exp_err});
        check({tag, "/rsp_we"}, {28'b0, b0.dmem_we}, 32'd0);
        @(posedge clk); #1;
        check({tag, "/rsp_drop"}, {30'b0, b0.rsp_valid}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] g;
        rst_n           = 1'b0;
        b0.req_valid    = 2'b00;
        b0.req_addr     = {32'h20, 32'h10};
        b0.req_wdata    = '0;
        b0.req_write    = 2'b00;
        b0.req_size     = 4'b1010;
        b0.req_unsigned = 2'b00;
        b1.req_valid    = 2'b00;
        b1.req_addr     = {32'h20, 32'h10};
        b1.req_wdata    = '0;
        b1.req_write    = 2'b00;
        b1.req_size     = 4'b1010;
        b1.req_unsigned = 2'b00;

        // reset state, with both requesters already valid
        repeat (2) @(negedge clk);
        b0.req_valid = 2'b11;
        b1.req_valid = 2'b11;
        #1;
        check("rst/ready_rr", {30'b0, b0.req_ready}, 32'd0);
        check("rst/ready_fp", {30'b0, b1.req_ready}, 32'd0);
        check("rst/rsp_valid", {30'b0, b0.rsp_valid}, 32'd0);
        check("rst/rsp_rdata", b0.rsp_rdata, 32'd0);
        check("rst/rsp_err", {31'b0, b0.rsp_err}, 32'd0);
        check("rst/dmem_we", {28'b0, b0.dmem_we}, 32'd0);
        check("rst/dmem_addr", b0.dmem_addr, 32'd0);
        check("rst/dmem_wdata", b0.dmem_wdata, 32'd0);

        // both ports held valid from release: RR alternates 0,1,0,1; fixed priority serves port 0 only
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            g = ((c / 3) % 2 == 1) ? 2'b10 : 2'b01;
            #1;
            check($sformatf("rr/ready%0d", c), {30'b0, b0.req_ready}, (c % 3 == 0) ? {30'b0, g} : 32'd0);
            check($sformatf("rr/rsp%0d", c), {30'b0, b0.rsp_valid}, (c % 3 == 2) ? {30'b0, g} : 32'd0);
            check($sformatf("fp/ready%0d", c), {30'b0, b1.req_ready}, (c % 3 == 0) ? 32'd1 : 32'd0);
            check($sformatf("fp/rsp%0d", c), {30'b0, b1.rsp_valid}, (c % 3 == 2) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        b0.req_valid = 2'b00;
        b1.req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);

        // stores and loads through the lane aligner
        access(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 4'b1111, 32'h11223344, 32'h0, 1'b0, "st_w10");
        access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 4'b0000, 32'h0, 32'h11223344, 1'b0, "ld_w10");
        access(1, 1'b1, 2'd0, 1'b0, 32'h21, 32'h80, 4'b0010, 32'h00008000, 32'h0, 1'b0, "st_b21");
        access(1, 1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 4'b0000, 32'h0, 32'hFFFFFF80, 1'b0, "ld_b21s");
        access(1, 1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 4'b0000, 32'h0, 32'h00000080, 1'b0, "ld_b21u");
        access(0, 1'b1, 2'd1, 1'b0, 32'h06, 32'hBEEF, 4'b1100, 32'hBEEF0000, 32'h0, 1'b0, "st_h06");
        access(0, 1'b0, 2'd1, 1'b0, 32'h06, 32'h0, 4'b0000, 32'h0, 32'hFFFFBEEF, 1'b0, "ld_h06s");
        access(0, 1'b0, 2'd1, 1'b1, 32'h06, 32'h0, 4'b0000, 32'h0, 32'h0000BEEF, 1'b0, "ld_h06u");
        access(1, 1'b1, 2'd0, 1'b0, 32'h7F, 32'h5A, 4'b1000, 32'h5A000000, 32'h0, 1'b0, "st_b7f");
        access(0, 1'b0, 2'd0, 1'b1, 32'h7F, 32'h0, 4'b0000, 32'h0, 32'h0000005A, 1'b0, "ld_b7f");

        // error cases: misaligned, out of range, illegal size
        access(0, 1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, "err_w13");
        access(1, 1'b0, 2'd1, 1'b0, 32'h05, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, "err_h05");
        access(0, 1'b0, 2'd0, 1'b0, 32'h80, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, "err_b80");
        access(1, 1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, "err_sz3");
        access(0, 1'b1, 2'd2, 1'b0, 32'h7E, 32'hDEADBEEF, 4'b0000, 32'h0, 32'h0, 1'b1, "err_stw7e");
        access(1, 1'b1, 2'd1, 1'b0, 32'h7F, 32'h1234, 4'b0000, 32'h0, 32'h0, 1'b1, "err_sth7f");
        access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 4'b0000, 32'h0, 32'h11223344, 1'b0, "ld_w10_again");

        // reset during the ACC cycle of a store
        b0.req_addr[31:0]  = 32'h40;
        b0.req_wdata[31:0] = 32'hCAFEF00D;
        b0.req_write[0]    = 1'b1;
        b0.req_size[1:0]   = 2'd2;
        b0.req_valid[0]    = 1'b1;
        #1;
        check("mid/ready", {30'b0, b0.req_ready}, 32'd1);
        @(posedge clk); #1;
        b0.req_valid[0] = 1'b0;
        check("mid/acc_we", {28'b0, b0.dmem_we}, 32'hF);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid/we", {28'b0, b0.dmem_we}, 32'd0);
        check("mid/addr", b0.dmem_addr, 32'd0);
        check("mid/wdata", b0.dmem_wdata, 32'd0);
        check("mid/rsp_valid", {30'b0, b0.rsp_valid}, 32'd0);
        check("mid/rsp_err", {31'b0, b0.rsp_err}, 32'd0);
        check("mid/rsp_rdata", b0.rsp_rdata, 32'd0);
        @(posedge clk); #1;
        check("mid/rsp_valid2", {30'b0, b0.rsp_valid}, 32'd0);
        check("mid/we2", {28'b0, b0.dmem_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        access(1, 1'b1, 2'd2, 1'b0, 32'h44, 32'h0BADCAFE, 4'b1111, 32'h0BADCAFE, 32'h0, 1'b0, "post_st");
        access(0, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 4'b0000, 32'h0, 32'h0BADCAFE, 1'b0, "post_ld");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory between two requesters: port 0 (CPU load/store unit) and port 1 (debug/DMA loader).
- Each port uses a valid/ready request and a one-cycle response pulse; the block arbitrates, checks alignment and range, and drives the memory's byte write-enables.
- Places byte/half/word store data on the correct memory lanes; extracts and sign/zero-extends load data.
- Sits between the core/debug logic and dmem; dmem is only ever driven by this block.

Parameters:
- PRIO_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 0 always wins.
- MEM_BYTES, 128, dmem size in bytes; any access touching byte address >= MEM_BYTES is an error.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  2  request valid, bit p = port p
- req_ready  out  2  request accepted this cycle, bit p
- req_addr  in  2x32  byte address per port (packed, port p at [32p+31:32p])
- req_wdata  in  2x32  store data, value right-justified
- req_write  in  2  1 = store, 0 = load
- req_size  in  2x2  0 byte, 1 half, 2 word; 3 is illegal
- req_unsigned  in  2  load zero-extends when 1
- rsp_valid  out  2  one-cycle response pulse to the granted port
- rsp_rdata  out  32  load result (0 for stores and errors)
- rsp_err  out  1  misaligned, out-of-range or illegal-size request
- dmem_addr  out  32  byte address to dmem (dmem word-aligns internally)
- dmem_wdata  out  32  lane-placed store data
- dmem_we  out  4  byte-lane write enables
- dmem_rdata  in  32  combinational read data; byte offset 0 on [31:24], offset 3 on [7:0]

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE; req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, dmem_we=0, dmem_addr=0, dmem_wdata=0; last-grant pointer = port 1, so port 0 wins the first tie.
- Reset mid-transaction aborts it: no write enable reaches dmem after the reset edge, and no response is issued.
- FSM IDLE -> ACC -> RSP -> IDLE.
- IDLE:
  - req_ready is combinational: asserted only for the winning port, only when that port's valid is high.
  - Handshake = valid & ready; the accepted request is registered.
  - If no port is valid, stay in IDLE.
- Arbitration:
  - PRIO_MODE 0: if both ports are valid, grant the port not granted last. The pointer updates only on acceptance.
  - PRIO_MODE 1: port 0 always wins.
- ACC (exactly one cycle):
  - dmem_addr = registered address.
  - dmem_we nonzero only for a legal store.
  - Load data is captured from dmem_rdata at the end of the cycle.
- RSP:
  - rsp_valid[granted]=1 for one cycle, with rsp_rdata and rsp_err valid.
  - Next state is IDLE.
- Latency: accept at cycle N, dmem write edge at end of N+1, rsp_valid at N+2. Maximum throughput is one access per 3 cycles.
- Error conditions, with k = addr[1:0]:
  - size 3;
  - half with k odd;
  - word with k != 0;
  - addr + bytes - 1 >= MEM_BYTES.
- On error: dmem_we=0 throughout, rsp_err=1, rsp_rdata=0, same timing as a normal access.
- Store lane placement:
  - byte: we bit k; wdata[7:0] on lane bits [8k+7:8k].
  - half: we bits k and k+1; wdata[15:0] on [8k+15:8k].
  - word: we=1111, dmem_wdata=wdata.
  - Unused lanes carry 0.
- Load extraction, with byte(j) = dmem_rdata[31-8j:24-8j]:
  - byte: byte(k).
  - half: {byte(k+1), byte(k)}.
  - word: {byte(3), byte(2), byte(1), byte(0)}.
  - Sign-extend from bit 7/15 unless req_unsigned.
- Store response: rsp_rdata=0, rsp_err=0.
- Held requests:
  - A requester's valid and request fields must stay stable until ready.
  - A non-granted valid request waits; it is never dropped.
- Requests arriving in ACC or RSP see req_ready=0.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2;
  - state encodings ST_IDLE, ST_ACC, ST_RSP;
  - function lane_we(size, k) returning the 4-bit enable.
- One sub-module, dmem_lane_align: combinational store placement, load extraction and sign extension. It is reused by the future I/O bridge.

Test Plan:
- Port 0 store word 0x11223344 @0x10 -> dmem_we=1111 at N+1; rsp_valid[0] at N+2; a later load word @0x10 returns 0x11223344.
- Port 1 store byte 0x80 @0x21, then signed load byte @0x21 -> dmem_we=0010 with dmem_wdata=0x00008000; load returns 0xFFFFFF80, or 0x00000080 with req_unsigned=1.
- Store half 0xBEEF @0x06; load half @0x06 -> dmem_we=1100; load returns 0xFFFFBEEF signed, 0x0000BEEF unsigned.
- Load word @0x13, half @0x05, byte @0x80 (MEM_BYTES=128), size=3 -> each gives rsp_err=1, rsp_rdata=0, dmem_we=0 every cycle.
- Both ports valid continuously, PRIO_MODE=0 -> grants alternate 0,1,0,1 from reset. PRIO_MODE=1 -> port 0 served every 3 cycles, port 1 never served while port 0 stays valid.
- rst_n low during the ACC of a store -> no dmem_we pulse after the reset edge; all outputs 0; state IDLE; a fresh request after release completes normally.
